pio_hs_peer: RTL and testbench
==============================

# pio_hs_peer

Peripheral-side partner for an i8255 port operating in mode 1 strobed I/O. The transmit channel feeds a mode-1 input port by driving data and STB_n and pacing on IBF. The receive channel drains a mode-1 output port by watching OBF_n and pulsing ACK_n. The block sits on the device side of the PIO pins, for example keyboard or cassette emulation logic, and presents simple FIFO/valid interfaces to that logic.

## Interface
- SETUP_CYC, 2: cycles data is driven before STB_n falls (1..15)
- STB_W, 4: STB_n low width in cycles (1..15)
- ACK_W, 4: ACK_n low width in cycles (1..15)
- TX_DEPTH, 4: transmit FIFO depth, power of two (2..16)
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  reset, asynchronous, active-high
- tx_we_i  in  1  push tx_dat_i into the TX FIFO; ignored when tx_full_o=1
- tx_dat_i  in  8  byte to send
- tx_full_o  out  1  TX FIFO full
- tx_busy_o  out  1  TX FSM not IDLE or FIFO non-empty
- pd_o  out  8  data to the 8255 input port
- pd_oe_o  out  1  pd_o drive enable
- stb_n_o  out  1  strobe to the 8255 (PC4 or PC2)
- ibf_i  in  1  IBF from the 8255 (PC5 or PC1), asynchronous
- pd_i  in  8  data from the 8255 output port
- obf_n_i  in  1  OBF_n from the 8255 (PC7 or PC1), asynchronous
- ack_n_o  out  1  acknowledge to the 8255 (PC6 or PC2)
- rx_dat_o  out  8  received byte
- rx_vld_o  out  1  rx_dat_o holds an unread byte
- rx_rd_i  in  1  consume rx_dat_o; clears rx_vld_o

## Operation
- Synchronizers: ibf_i and obf_n_i each pass through 2 flops, producing ibf_s and obf_n_s. On reset, ibf_s is 0 and obf_n_s is 1.
- Reset values: pd_o=0, pd_oe_o=0, stb_n_o=1, ack_n_o=1, rx_dat_o=0, rx_vld_o=0, tx_full_o=0, tx_busy_o=0. The FIFO is emptied and both FSMs go to IDLE.
- Reset is asynchronous. If it is asserted mid-transfer, the block abandons the transfer at once: stb_n_o and ack_n_o return high and pd_oe_o drops.
- TX FIFO:
  - Circular buffer of TX_DEPTH bytes with pointers one bit wider than the index.
  - A write while full is dropped and changes no state.
  - A push and pop in the same cycle are both honoured, and the count is unchanged.
- TX FSM states: IDLE, SETUP, STRB, HOLD.
  - IDLE→SETUP when the FIFO is non-empty and ibf_s=0. On this transition the head is loaded into pd_o, the FIFO is popped, and pd_oe_o is set to 1.
  - SETUP→STRB after SETUP_CYC cycles. stb_n_o goes to 0 on entry to STRB.
  - STRB→HOLD after STB_W cycles. stb_n_o goes to 1 on entry to HOLD, and data is still driven.
  - HOLD→IDLE after 3 cycles, which covers synchronizer latency so that IBF is seen high before the next start. pd_oe_o goes to 0 on entry to IDLE; pd_o keeps its value.
  - A new byte never starts while ibf_s=1. A byte is therefore never overwritten before the CPU has read it.
- RX FSM states: IDLE, ACK, REL.
  - IDLE→ACK when obf_n_s=0 and rx_vld_o=0. ack_n_o goes to 0. This is backpressure: no ACK is issued while a byte is still unread.
  - ACK→REL after ACK_W cycles. On the last ACK cycle, pd_i is registered into rx_dat_o and rx_vld_o is set. ack_n_o goes to 1 on entry to REL.
  - REL→IDLE when obf_n_s=1. The 8255 raises OBF_n on the falling edge of ACK.
- rx_rd_i with rx_vld_o=1 clears rx_vld_o on the next edge. If rx_rd_i arrives in the same cycle as a capture, the capture wins and rx_vld_o stays 1.
- The TX and RX channels are fully independent and may run concurrently.

## Timing
- Cycle numbering: tx_we_i is sampled at edge k with the FIFO empty and ibf_s=0.
  - At edge k+1: SETUP begins and pd_oe_o=1.
  - At edge k+1+SETUP_CYC: stb_n_o=0.
  - At edge k+1+SETUP_CYC+STB_W: stb_n_o=1.
  - At edge k+4+SETUP_CYC+STB_W: pd_oe_o=0.
- Minimum byte period is 4+SETUP_CYC+STB_W cycles. With the defaults this is 10.
- RX: when obf_n_i falls, ack_n_o falls 3 edges later (2 synchronizer edges plus 1 FSM edge). rx_vld_o rises ACK_W edges after that.
- tx_full_o and tx_busy_o are registered and reflect the state after each edge.

## Test plan
- Reset mid-STRB: assert rst_i asynchronously while stb_n_o=0. Required: stb_n_o=1 and pd_oe_o=0 without waiting for a clock edge; after release the FIFO is empty and tx_busy_o=0.
- TX single byte, defaults, ibf_i held 0: push 0xA5. Required: pd_o=0xA5 with pd_oe_o=1 from cycle k+1; stb_n_o low exactly 4 cycles starting at k+3; pd_oe_o=0 at k+10.
- TX backpressure: push 0x11, 0x22, then raise ibf_i 2 cycles after stb_n_o rises and hold it 20 cycles. Required: the second strobe does not occur until 2+ cycles after ibf_i falls; the bytes go out in order 0x11, 0x22.
- FIFO full: push 5 bytes back-to-back with ibf_i=1. Required: tx_full_o=1 after the 4th push; the 5th byte is dropped; after ibf_i is released exactly 4 strobes occur.
- RX with backpressure: set pd_i=0x3C and drive obf_n_i low; model the 8255 by raising obf_n_i when ack_n_o falls. Required: ack_n_o low for 4 cycles; rx_dat_o=0x3C and rx_vld_o=1. Then hold rx_rd_i=0 and drop obf_n_i again with pd_i=0x55. Required: no ACK until rx_rd_i is pulsed, then 0x55 is captured.
- Concurrency: run the TX and RX scenarios simultaneously. Required: identical per-channel waveforms.

Source files
------------

// File: rtl/pio_hs_peer_if.sv
// Pin- and FIFO-side signal bundle for the i8255 mode-1 peripheral partner.
// Handshakes: tx_we_i pushes one byte per cycle unless tx_full_o=1 (dropped);
// rx_vld_o holds a byte until a cycle with rx_rd_i=1, after which it clears.
interface pio_hs_peer_if;
  logic       tx_we_i;
  logic [7:0] tx_dat_i;
  logic       tx_full_o;
  logic       tx_busy_o;
  logic [7:0] pd_o;
  logic       pd_oe_o;
  logic       stb_n_o;
  logic       ibf_i;
  logic [7:0] pd_i;
  logic       obf_n_i;
  logic       ack_n_o;
  logic [7:0] rx_dat_o;
  logic       rx_vld_o;
  logic       rx_rd_i;

  modport slave (
    input  tx_we_i, tx_dat_i, ibf_i, pd_i, obf_n_i, rx_rd_i,
    output tx_full_o, tx_busy_o, pd_o, pd_oe_o, stb_n_o, ack_n_o,
           rx_dat_o, rx_vld_o
  );

  modport master (
    output tx_we_i, tx_dat_i, ibf_i, pd_i, obf_n_i, rx_rd_i,
    input  tx_full_o, tx_busy_o, pd_o, pd_oe_o, stb_n_o, ack_n_o,
           rx_dat_o, rx_vld_o
  );
endinterface

// File: rtl/pio_hs_peer.sv
// Device-side partner for an i8255 mode-1 port pair: a FIFO-fed strobed
// transmitter paced by IBF and an ACK-pulsing receiver paced by OBF_n.
module pio_hs_peer #(
  parameter int SETUP_CYC = 2,
  parameter int STB_W     = 4,
  parameter int ACK_W     = 4,
  parameter int TX_DEPTH  = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  pio_hs_peer_if.slave bus,
  output logic [1:0] tx_state_o,
  output logic [1:0] rx_state_o
);

  localparam int AW = (TX_DEPTH > 2) ? $clog2(TX_DEPTH) : 1;

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STB_LAST   = 4'(STB_W - 1);
  localparam logic [3:0] HOLD_LAST  = 4'd2;
  localparam logic [3:0] ACK_LAST   = 4'(ACK_W - 1);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SETUP = 2'd1,
    TX_STRB  = 2'd2,
    TX_HOLD  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_ACK  = 2'd1,
    RX_REL  = 2'd2
  } rx_state_t;

  // ---------------------------------------------------------------------
  // Synchronizers for the two asynchronous 8255 status pins
  // ---------------------------------------------------------------------
  logic [1:0] ibf_sync;
  logic [1:0] obf_sync;
  logic       ibf_s;
  logic       obf_n_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ibf_sync <= 2'b00;
      obf_sync <= 2'b11;
    end else begin
      ibf_sync <= {ibf_sync[0], bus.ibf_i};
      obf_sync <= {obf_sync[0], bus.obf_n_i};
    end
  end

  assign ibf_s   = ibf_sync[1];
  assign obf_n_s = obf_sync[1];

  // ---------------------------------------------------------------------
  // TX FIFO: pointers carry one extra wrap bit to tell full from empty
  // ---------------------------------------------------------------------
  logic [7:0]  mem [TX_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = bus.tx_we_i && !fifo_full;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= bus.tx_dat_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------
  tx_state_t  tx_state;
  tx_state_t  tx_next;
  logic [3:0] tx_cnt;
  logic       tx_cnt_done;
  logic [7:0] pd_q;
  logic       stb_n;
  logic       pd_oe;

  // A new byte only starts once the 8255 has drained the previous one.
  assign pop = (tx_state == TX_IDLE) && !fifo_empty && !ibf_s;

  always_comb begin
    tx_cnt_done = 1'b0;
    unique case (tx_state)
      TX_SETUP: tx_cnt_done = (tx_cnt == SETUP_LAST);
      TX_STRB:  tx_cnt_done = (tx_cnt == STB_LAST);
      TX_HOLD:  tx_cnt_done = (tx_cnt == HOLD_LAST);
      default:  tx_cnt_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= 4'd0;
    end else begin
      tx_state <= tx_next;
      if (tx_next != tx_state || tx_next == TX_IDLE) begin
        tx_cnt <= 4'd0;
      end else begin
        tx_cnt <= tx_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      TX_IDLE:  if (pop)         tx_next = TX_SETUP;
      TX_SETUP: if (tx_cnt_done) tx_next = TX_STRB;
      TX_STRB:  if (tx_cnt_done) tx_next = TX_HOLD;
      TX_HOLD:  if (tx_cnt_done) tx_next = TX_IDLE;
      default:                   tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    stb_n = 1'b1;
    pd_oe = 1'b0;
    unique case (tx_state)
      TX_SETUP: pd_oe = 1'b1;
      TX_STRB: begin
        stb_n = 1'b0;
        pd_oe = 1'b1;
      end
      TX_HOLD:  pd_oe = 1'b1;
      default: begin
        stb_n = 1'b1;
        pd_oe = 1'b0;
      end
    endcase
  end

  // pd_o keeps the last byte after the drive enable drops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pd_q <= 8'h00;
    end else if (pop) begin
      pd_q <= mem[rd_ptr[AW-1:0]];
    end
  end

  // ---------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------
  rx_state_t  rx_state;
  rx_state_t  rx_next;
  logic [3:0] rx_cnt;
  logic       rx_capture;
  logic       ack_n;
  logic [7:0] rx_dat_q;
  logic       rx_vld_q;

  assign rx_capture = (rx_state == RX_ACK) && (rx_cnt == ACK_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= 4'd0;
    end else begin
      rx_state <= rx_next;
      if (rx_next != rx_state || rx_next != RX_ACK) begin
        rx_cnt <= 4'd0;
      end else begin
        rx_cnt <= rx_cnt + 4'd1;
      end
    end
  end

  // No ACK is issued while the previous byte is still unread.
  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE: if (!obf_n_s && !rx_vld_q) rx_next = RX_ACK;
      RX_ACK:  if (rx_capture)            rx_next = RX_REL;
      RX_REL:  if (obf_n_s)               rx_next = RX_IDLE;
      default:                            rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    ack_n = 1'b1;
    unique case (rx_state)
      RX_ACK:  ack_n = 1'b0;
      default: ack_n = 1'b1;
    endcase
  end

  // A capture in the same cycle as a read keeps the new byte valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_dat_q <= 8'h00;
      rx_vld_q <= 1'b0;
    end else if (rx_capture) begin
      rx_dat_q <= bus.pd_i;
      rx_vld_q <= 1'b1;
    end else if (bus.rx_rd_i) begin
      rx_vld_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.pd_o      = pd_q;
  assign bus.pd_oe_o   = pd_oe;
  assign bus.stb_n_o   = stb_n;
  assign bus.tx_full_o = fifo_full;
  assign bus.tx_busy_o = (tx_state != TX_IDLE) || !fifo_empty;
  assign bus.ack_n_o   = ack_n;
  assign bus.rx_dat_o  = rx_dat_q;
  assign bus.rx_vld_o  = rx_vld_q;

  assign tx_state_o = tx_state;
  assign rx_state_o = rx_state;

  // Strobe without driven data, or an ACK over an unread byte, is a bug.
  a_stb_has_data: assert property (@(posedge clk_i) disable iff (rst_i)
    !stb_n |-> pd_oe);
  a_no_ack_unread: assert property (@(posedge clk_i) disable iff (rst_i)
    (rx_state == RX_IDLE && rx_next == RX_ACK) |-> !rx_vld_q);

endmodule

// File: tb/tb_pio_hs_peer.sv
// Randomized bench for pio_hs_peer: behavioural 8255 port models on the pin
// side, expected-byte queues filled at issue time, negedge monitors checking.
module tb_pio_hs_peer;
  localparam int SETUP_CYC = 2;
  localparam int STB_W     = 4;
  localparam int ACK_W     = 4;
  localparam int TX_DEPTH  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pio_hs_peer_if bus ();
  logic [1:0] dbg_tx_state;
  logic [1:0] dbg_rx_state;

  pio_hs_peer #(
    .SETUP_CYC(SETUP_CYC), .STB_W(STB_W), .ACK_W(ACK_W), .TX_DEPTH(TX_DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus.slave),
    .tx_state_o (dbg_tx_state),
    .rx_state_o (dbg_rx_state)
  );

  // ---------------- scoreboard state ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  int strobe_cnt = 0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  logic [7:0] rx_src_q[$];
  bit ibf_hold = 1'b0;
  bit rd_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s: condition not reached within its bound", name);
  endtask

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic tx_push(input logic [7:0] b, input bit accept);
    bus.tx_dat_i = b;
    bus.tx_we_i  = 1'b1;
    if (accept) tx_exp_q.push_back(b);
    @(posedge clk); #1;
    bus.tx_we_i = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- 8255 input-port model: STB_n sets IBF, CPU read clears ----
  logic ibf_flag = 1'b0;
  int   rd_cnt = 0;
  initial begin
    bus.ibf_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.stb_n_o == 1'b0) begin
        ibf_flag = 1'b1;
        rd_cnt = $urandom_range(0, 12);
      end else if (ibf_flag) begin
        if (rd_cnt == 0) ibf_flag = 1'b0;
        else rd_cnt--;
      end
      bus.ibf_i = ibf_flag | ibf_hold;
    end
  end

  // ---------------- 8255 output-port model: OBF_n low, released by ACK_n ----
  initial begin
    logic [7:0] b;
    logic vld_at_drop;
    int n;
    bus.obf_n_i = 1'b1;
    bus.pd_i = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!rst && rx_src_q.size() > 0) begin
        b = rx_src_q.pop_front();
        bus.pd_i = b;
        bus.obf_n_i = 1'b0;
        rx_exp_q.push_back(b);
        vld_at_drop = bus.rx_vld_o;
        n = 0;
        while (bus.ack_n_o && n < 2000) begin @(posedge clk); #1; n++; end
        if (n >= 2000) fail("rx_ack_timeout");
        else if (!vld_at_drop) chk("rx_ack_latency", n, 3);
        bus.obf_n_i = 1'b1;
        n = 0;
        while (!bus.ack_n_o && n < 40) begin @(posedge clk); #1; n++; end
        if (n >= 40) fail("rx_ack_release_timeout");
        wait_cycles($urandom_range(1, 6));
      end
    end
  end

  // ---------------- consumer: random reads, also while nothing is valid -----
  initial begin
    bus.rx_rd_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.rx_rd_i = rd_en && ($urandom_range(0, 3) == 0);
    end
  end

  // ---------------- TX monitor ----------------
  logic stb_prev = 1'b1;
  logic oe_prev = 1'b0;
  int stb_low_cnt = 0;
  int oe_run = 0;
  int ibf_low_run = 0;
  always @(negedge clk) begin
    if (rst) begin
      stb_prev = 1'b1;
      oe_prev = 1'b0;
      stb_low_cnt = 0;
      oe_run = 0;
    end else begin
      if (bus.stb_n_o == 1'b0 && stb_prev) begin
        strobe_cnt++;
        chk("tx_ibf_low_before_strobe", (ibf_low_run >= SETUP_CYC + 3) ? 1 : 0, 1);
        chk("tx_setup_cycles", oe_run, SETUP_CYC);
        chk("tx_oe_at_strobe", bus.pd_oe_o, 1);
        if (tx_exp_q.size() == 0) fail("tx_unexpected_strobe");
        else chk("tx_byte", bus.pd_o, tx_exp_q.pop_front());
      end
      if (bus.stb_n_o == 1'b0) begin
        stb_low_cnt++;
      end else if (!stb_prev) begin
        chk("tx_strobe_width", stb_low_cnt, STB_W);
        chk("tx_oe_after_strobe", bus.pd_oe_o, 1);
        stb_low_cnt = 0;
      end
      if (!bus.pd_oe_o && oe_prev) chk("tx_byte_period", oe_run, SETUP_CYC + STB_W + 3);
      oe_run = bus.pd_oe_o ? oe_run + 1 : 0;
      stb_prev = bus.stb_n_o;
      oe_prev = bus.pd_oe_o;
    end
    ibf_low_run = bus.ibf_i ? 0 : ibf_low_run + 1;
  end

  // ---------------- RX monitor ----------------
  logic ack_prev = 1'b1;
  logic vld_prev = 1'b0;
  int ack_low_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      ack_prev = 1'b1;
      vld_prev = 1'b0;
      ack_low_cnt = 0;
    end else begin
      if (!bus.ack_n_o && ack_prev) chk("rx_ack_while_unread", vld_prev, 0);
      if (!bus.ack_n_o) begin
        ack_low_cnt++;
      end else if (!ack_prev) begin
        chk("rx_ack_width", ack_low_cnt, ACK_W);
        ack_low_cnt = 0;
      end
      if (bus.rx_vld_o && !vld_prev) begin
        chk("rx_vld_at_ack_release", {30'd0, ack_prev, bus.ack_n_o}, 32'd1);
        if (rx_exp_q.size() == 0) fail("rx_unexpected_byte");
        else chk("rx_byte", bus.rx_dat_o, rx_exp_q.pop_front());
      end
      ack_prev = bus.ack_n_o;
      vld_prev = bus.rx_vld_o;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int s0;
    bus.tx_we_i = 1'b0;
    bus.tx_dat_i = 8'h00;

    // Reset values
    wait_cycles(3);
    chk("rst_stb_n", bus.stb_n_o, 1);
    chk("rst_ack_n", bus.ack_n_o, 1);
    chk("rst_pd_oe", bus.pd_oe_o, 0);
    chk("rst_pd", bus.pd_o, 8'h00);
    chk("rst_rx_vld", bus.rx_vld_o, 0);
    chk("rst_rx_dat", bus.rx_dat_o, 8'h00);
    chk("rst_full", bus.tx_full_o, 0);
    chk("rst_busy", bus.tx_busy_o, 0);
    rst = 1'b0;
    wait_cycles(4);

    // Single byte cycle-exact timing
    tx_push(8'hA5, 1'b1);
    wait_cycles(1);
    chk("tx1_oe_k1", bus.pd_oe_o, 1);
    chk("tx1_pd_k1", bus.pd_o, 8'hA5);
    chk("tx1_stb_k1", bus.stb_n_o, 1);
    wait_cycles(SETUP_CYC);
    chk("tx1_stb_k3", bus.stb_n_o, 0);
    wait_cycles(STB_W - 1);
    chk("tx1_stb_k6", bus.stb_n_o, 0);
    wait_cycles(1);
    chk("tx1_stb_k7", bus.stb_n_o, 1);
    chk("tx1_oe_k7", bus.pd_oe_o, 1);
    wait_cycles(2);
    chk("tx1_oe_k9", bus.pd_oe_o, 1);
    wait_cycles(1);
    chk("tx1_oe_k10", bus.pd_oe_o, 0);
    chk("tx1_pd_k10", bus.pd_o, 8'hA5);
    wait_cycles(20);

    // Asynchronous reset in the middle of a strobe
    tx_push(8'h5A, 1'b1);
    tx_push(8'h77, 1'b1);
    tx_push(8'h88, 1'b1);
    n = 0;
    while (bus.stb_n_o && n < 100) begin wait_cycles(1); n++; end
    if (n >= 100) fail("rst_wait_strobe");
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_stb_n", bus.stb_n_o, 1);
    chk("rst_mid_pd_oe", bus.pd_oe_o, 0);
    tx_exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    wait_cycles(1);
    chk("rst_mid_busy", bus.tx_busy_o, 0);
    chk("rst_mid_full", bus.tx_full_o, 0);
    wait_cycles(20);
    chk("rst_mid_busy_later", bus.tx_busy_o, 0);
    chk("rst_mid_no_strobe", bus.stb_n_o, 1);

    // FIFO fill with IBF held, fifth write dropped
    ibf_hold = 1'b1;
    wait_cycles(4);
    s0 = strobe_cnt;
    for (int i = 0; i < TX_DEPTH; i++) begin
      tx_push(8'h10 + 8'(i), 1'b1);
      chk("fifo_full_flag", bus.tx_full_o, (i == TX_DEPTH - 1) ? 1 : 0);
    end
    tx_push(8'hEE, 1'b0);
    chk("fifo_full_after_drop", bus.tx_full_o, 1);
    chk("fifo_busy_held", bus.tx_busy_o, 1);
    wait_cycles(10);
    chk("fifo_no_strobe_while_ibf", strobe_cnt - s0, 0);
    ibf_hold = 1'b0;
    n = 0;
    while (bus.tx_busy_o && n < 1000) begin wait_cycles(1); n++; end
    if (n >= 1000) fail("fifo_drain_timeout");
    chk("fifo_strobe_count", strobe_cnt - s0, TX_DEPTH);
    chk("fifo_full_cleared", bus.tx_full_o, 0);

    // RX with consumer backpressure
    rd_en = 1'b0;
    wait_cycles(2);
    rx_src_q.push_back(8'h3C);
    n = 0;
    while (!bus.rx_vld_o && n < 100) begin wait_cycles(1); n++; end
    if (n >= 100) fail("rx1_vld_timeout");
    chk("rx1_dat", bus.rx_dat_o, 8'h3C);
    rx_src_q.push_back(8'h55);
    wait_cycles(30);
    chk("rx_bp_ack_high", bus.ack_n_o, 1);
    chk("rx_bp_vld", bus.rx_vld_o, 1);
    chk("rx_bp_dat", bus.rx_dat_o, 8'h3C);
    rd_en = 1'b1;
    n = 0;
    while (rx_exp_q.size() != 0 && n < 200) begin wait_cycles(1); n++; end
    if (n >= 200) fail("rx2_capture_timeout");

    // Concurrent random traffic on both channels
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int w;
          wait_cycles($urandom_range(0, 8));
          w = 0;
          while (bus.tx_full_o && w < 2000) begin wait_cycles(1); w++; end
          if (w >= 2000) fail("tx_full_stuck");
          tx_push(8'($urandom_range(0, 255)), 1'b1);
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          rx_src_q.push_back(8'($urandom_range(0, 255)));
          wait_cycles($urandom_range(1, 25));
        end
      end
    join
    n = 0;
    while ((tx_exp_q.size() != 0 || rx_exp_q.size() != 0 || rx_src_q.size() != 0 ||
            bus.tx_busy_o) && n < 20000) begin
      wait_cycles(1);
      n++;
    end
    if (n >= 20000) fail("drain_timeout");
    wait_cycles(20);
    chk("end_tx_queue_empty", tx_exp_q.size(), 0);
    chk("end_rx_queue_empty", rx_exp_q.size(), 0);
    chk("end_tx_idle", bus.tx_busy_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
